// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and a DMA port with burst hold and starvation bounds
module dmem_arbiter #(
  parameter int MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [63:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [63:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam logic [3:0] MW = 4'(MAXWAIT);
  state_t     r_state;
  logic [3:0] r_cpu_wait;
  logic [3:0] r_dma_wait;
  logic       w_burst;
  logic       w_cpu_force;
  logic       w_dma_force;
  assign w_burst     = r_state == BURST;
  assign w_cpu_force = cpu_req && r_cpu_wait == MW;
  assign w_dma_force = dma_req && r_dma_wait == MW;
  // In BURST the DMA owns the memory unless the CPU has waited MAXWAIT cycles; in IDLE the CPU wins unless the DMA has
  assign cpu_gnt = reset && cpu_req && (w_burst ? (!dma_req || w_cpu_force) : !w_dma_force);
  assign dma_gnt = reset && dma_req && (w_burst ? !w_cpu_force : (!cpu_req || w_dma_force));
  assign mem_we    = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
  assign mem_addr  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : 64'd0;
  assign mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : 64'd0;
  // Burst tracking and saturating wait counters; a forced CPU cycle leaves the DMA beat pending so BURST is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cpu_wait <= 4'd0;
      r_dma_wait <= 4'd0;
    end else begin
      r_state    <= w_burst ? (((dma_gnt && dma_last) || !dma_req) ? IDLE : BURST)
                            : ((dma_gnt && !dma_last) ? BURST : IDLE);
      r_cpu_wait <= (cpu_req && !cpu_gnt) ? ((r_cpu_wait == MW) ? MW : r_cpu_wait + 4'd1) : 4'd0;
      r_dma_wait <= (dma_req && !dma_gnt) ? ((r_dma_wait == MW) ? MW : r_dma_wait + 4'd1) : 4'd0;
    end
  end
  // Granted reads capture memory data for the issuing side and pulse its rvalid the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= 64'd0;
      dma_rdata  <= 64'd0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dma_rvalid <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
    end
  end
endmodule
